// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared encodings, defaults and the register-hazard helper for pipe_hazard_ctrl.
package pipe_hazard_ctrl_pkg;

  localparam logic [1:0] TUSE_NONE   = 2'd3;
  localparam logic [1:0] TNEW_ALU_E  = 2'd1;
  localparam logic [1:0] TNEW_LOAD_E = 2'd2;
  localparam logic [1:0] TNEW_LOAD_M = 2'd1;

  localparam int unsigned MULT_CYC_DEF = 5;
  localparam int unsigned DIV_CYC_DEF  = 10;
  localparam int unsigned MD_CNT_W     = 4;

  typedef logic [MD_CNT_W-1:0] md_cnt_t;

  // A producer only blocks the reader if its result lands after the reader needs it.
  function automatic logic reg_hazard(input logic [4:0] src, input logic [1:0] tuse,
                                      input logic [4:0] wa, input logic [1:0] tnew);
    return (src == wa) && (wa != 5'd0) && (tnew > tuse);
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Datapath-side bundle of stage timing fields and pipeline-register controls.
interface pipe_hazard_ctrl_if;
  logic [4:0]  D_rs;
  logic [4:0]  D_rt;
  logic [1:0]  D_rs_tuse;
  logic [1:0]  D_rt_tuse;
  logic        D_md_use;
  logic [4:0]  E_wa;
  logic [4:0]  M_wa;
  logic [1:0]  E_tnew;
  logic [1:0]  M_tnew;
  logic        E_md_start;
  logic        E_md_div;
  logic        stall;
  logic        PC_WrEn;
  logic        FD_WrEn;
  logic        DE_flush;
  logic        DE_WrEn;
  logic        EM_WrEn;
  logic        EM_flush;
  logic        md_busy;
  logic [31:0] stall_cnt;

  modport master (
    output D_rs, D_rt, D_rs_tuse, D_rt_tuse, D_md_use, E_wa, M_wa, E_tnew, M_tnew,
           E_md_start, E_md_div,
    input  stall, PC_WrEn, FD_WrEn, DE_flush, DE_WrEn, EM_WrEn, EM_flush, md_busy, stall_cnt
  );

  modport slave (
    input  D_rs, D_rt, D_rs_tuse, D_rt_tuse, D_md_use, E_wa, M_wa, E_tnew, M_tnew,
           E_md_start, E_md_div,
    output stall, PC_WrEn, FD_WrEn, DE_flush, DE_WrEn, EM_WrEn, EM_flush, md_busy, stall_cnt
  );
endinterface

// File: rtl/pipe_hazard_ctrl_md_busy_tracker.sv
// Occupancy counter for the multi-cycle multiply/divide unit.
module pipe_hazard_ctrl_md_busy_tracker
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int unsigned MULT_CYC = MULT_CYC_DEF,
  parameter int unsigned DIV_CYC  = DIV_CYC_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic i_md_start,
  input  logic i_md_div,
  output logic o_md_busy
);

  md_cnt_t r_md_cnt;
  md_cnt_t w_md_cnt_d;

  always_comb begin
    w_md_cnt_d = r_md_cnt;
    if (i_md_start) begin
      w_md_cnt_d = i_md_div ? md_cnt_t'(DIV_CYC) : md_cnt_t'(MULT_CYC);
    end else if (r_md_cnt != '0) begin
      w_md_cnt_d = r_md_cnt - md_cnt_t'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_md_cnt <= '0;
    end else begin
      r_md_cnt <= w_md_cnt_d;
    end
  end

  assign o_md_busy = i_md_start | (r_md_cnt != '0);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush controller: Tuse/Tnew RAW hazards plus mult/div occupancy.
// Optional stall-cycle counter enabled by defining STALL_CNT_EN.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int unsigned MULT_CYC = MULT_CYC_DEF,
  parameter int unsigned DIV_CYC  = DIV_CYC_DEF
) (
  input logic              clk,
  input logic              reset,
  pipe_hazard_ctrl_if.slave io_hz
);

  logic w_rs_hazard;
  logic w_rt_hazard;
  logic w_md_busy;
  logic w_stall;

  pipe_hazard_ctrl_md_busy_tracker #(
    .MULT_CYC (MULT_CYC),
    .DIV_CYC  (DIV_CYC)
  ) u_md_busy_tracker (
    .clk        (clk),
    .reset      (reset),
    .i_md_start (io_hz.E_md_start),
    .i_md_div   (io_hz.E_md_div),
    .o_md_busy  (w_md_busy)
  );

  assign w_rs_hazard =
      reg_hazard(io_hz.D_rs, io_hz.D_rs_tuse, io_hz.E_wa, io_hz.E_tnew) |
      reg_hazard(io_hz.D_rs, io_hz.D_rs_tuse, io_hz.M_wa, io_hz.M_tnew);
  assign w_rt_hazard =
      reg_hazard(io_hz.D_rt, io_hz.D_rt_tuse, io_hz.E_wa, io_hz.E_tnew) |
      reg_hazard(io_hz.D_rt, io_hz.D_rt_tuse, io_hz.M_wa, io_hz.M_tnew);

  assign w_stall = w_rs_hazard | w_rt_hazard | (io_hz.D_md_use & w_md_busy);

  assign io_hz.stall    = w_stall;
  assign io_hz.PC_WrEn  = ~w_stall;
  assign io_hz.FD_WrEn  = ~w_stall;
  assign io_hz.DE_flush = w_stall;
  assign io_hz.DE_WrEn  = 1'b1;
  assign io_hz.EM_WrEn  = 1'b1;
  assign io_hz.EM_flush = 1'b0;
  assign io_hz.md_busy  = w_md_busy;

`ifdef STALL_CNT_EN
  logic [31:0] r_stall_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stall_cnt <= '0;
    end else if (w_stall && (r_stall_cnt != 32'hFFFF_FFFF)) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign io_hz.stall_cnt = r_stall_cnt;
`else
  assign io_hz.stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl (directed scenarios plus random traffic).
module tb_pipe_hazard_ctrl;
  import pipe_hazard_ctrl_pkg::*;

  localparam int unsigned MULT = MULT_CYC_DEF;
  localparam int unsigned DIV  = DIV_CYC_DEF;

  logic clk = 1'b0;
  logic reset;
  int   n_vec  = 0;
  int   n_miss = 0;

  // Reference state: absolute cycle index and last cycle the md unit is occupied.
  int          cyc      = 0;
  int          busy_end = -1;
  logic [31:0] m_cnt    = 32'd0;

  pipe_hazard_ctrl_if bus ();

  pipe_hazard_ctrl #(
    .MULT_CYC (MULT),
    .DIV_CYC  (DIV)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .io_hz (bus)
  );

  always #5 clk = ~clk;

  function automatic logic hit(input logic [4:0] src, input logic [1:0] tuse);
    return ((src == bus.E_wa) && (bus.E_wa != 5'd0) && (int'(bus.E_tnew) > int'(tuse))) ||
           ((src == bus.M_wa) && (bus.M_wa != 5'd0) && (int'(bus.M_tnew) > int'(tuse)));
  endfunction

  function automatic logic [7:0] vec_of(input logic st, input logic busy);
    return {st, ~st, ~st, st, 1'b1, 1'b1, 1'b0, busy};
  endfunction

  function automatic logic [7:0] exp_vec();
    logic busy;
    logic st;
    busy = bus.E_md_start || (cyc <= busy_end);
    st   = hit(bus.D_rs, bus.D_rs_tuse) || hit(bus.D_rt, bus.D_rt_tuse) ||
           (bus.D_md_use && busy);
    return vec_of(st, busy);
  endfunction

  function automatic logic [7:0] obs_vec();
    return {bus.stall, bus.PC_WrEn, bus.FD_WrEn, bus.DE_flush,
            bus.DE_WrEn, bus.EM_WrEn, bus.EM_flush, bus.md_busy};
  endfunction

  function automatic logic [31:0] exp_cnt();
`ifdef STALL_CNT_EN
    return m_cnt;
`else
    return 32'd0;
`endif
  endfunction

  // Advance one clock edge, updating the reference from the inputs seen at that edge.
  task automatic tick();
    logic [7:0] v;
    v = exp_vec();
    @(posedge clk);
    if (!reset) begin
      if (v[7] && (m_cnt != 32'hFFFF_FFFF)) m_cnt = m_cnt + 32'd1;
      if (bus.E_md_start) busy_end = cyc + int'(bus.E_md_div ? DIV : MULT);
    end
    cyc = cyc + 1;
    #1;
  endtask

  task automatic set_idle();
    bus.D_rs = 5'd0;  bus.D_rt = 5'd0;
    bus.D_rs_tuse = TUSE_NONE;  bus.D_rt_tuse = TUSE_NONE;
    bus.D_md_use = 1'b0;
    bus.E_wa = 5'd0;  bus.M_wa = 5'd0;
    bus.E_tnew = 2'd0;  bus.M_tnew = 2'd0;
    bus.E_md_start = 1'b0;  bus.E_md_div = 1'b0;
  endtask

  task automatic do_reset();
    set_idle();
    reset = 1'b1;
    busy_end = -1;
    m_cnt = 32'd0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    logic [7:0] o;
    do_reset();
    @(negedge clk);
    o = obs_vec();
    n_vec++;
    if (o !== vec_of(1'b0, 1'b0)) begin
      n_miss++;
      $display("FAIL reset_outputs: got %b want %b", o, vec_of(1'b0, 1'b0));
    end
    n_vec++;
    if (bus.stall_cnt !== 32'd0) begin
      n_miss++;
      $display("FAIL reset_stall_cnt: got %0d want 0", bus.stall_cnt);
    end
    tick();
  endtask

  task automatic test_load_use();
    logic [7:0] o;
    set_idle();
    bus.E_wa = 5'd8;  bus.E_tnew = TNEW_LOAD_E;  bus.D_rs = 5'd8;  bus.D_rs_tuse = 2'd0;
    @(negedge clk);
    o = obs_vec();
    n_vec++;
    if (o !== vec_of(1'b1, 1'b0)) begin
      n_miss++;
      $display("FAIL load_use_stall: got %b want %b", o, vec_of(1'b1, 1'b0));
    end
    tick();
    bus.E_wa = 5'd0;
    @(negedge clk);
    o = obs_vec();
    n_vec++;
    if (o !== vec_of(1'b0, 1'b0)) begin
      n_miss++;
      $display("FAIL load_use_r0: got %b want %b", o, vec_of(1'b0, 1'b0));
    end
    tick();
  endtask

  task automatic test_m_stage();
    logic [7:0] o;
    set_idle();
    bus.M_wa = 5'd9;  bus.M_tnew = TNEW_LOAD_M;  bus.D_rt = 5'd9;  bus.D_rt_tuse = 2'd0;
    @(negedge clk);
    o = obs_vec();
    n_vec++;
    if (o !== vec_of(1'b1, 1'b0)) begin
      n_miss++;
      $display("FAIL m_stage_stall: got %b want %b", o, vec_of(1'b1, 1'b0));
    end
    tick();
    bus.D_rt_tuse = 2'd1;
    @(negedge clk);
    o = obs_vec();
    n_vec++;
    if (o !== vec_of(1'b0, 1'b0)) begin
      n_miss++;
      $display("FAIL m_stage_tuse1: got %b want %b", o, vec_of(1'b0, 1'b0));
    end
    tick();
  endtask

  task automatic test_md(input logic is_div);
    logic [7:0] o;
    int         n;
    n = int'(is_div ? DIV : MULT);
    do_reset();
    bus.D_md_use = 1'b1;  bus.E_md_start = 1'b1;  bus.E_md_div = is_div;
    for (int k = 0; k <= n + 2; k++) begin
      @(negedge clk);
      o = obs_vec();
      n_vec++;
      if (o !== vec_of(k <= n, k <= n)) begin
        n_miss++;
        $display("FAIL md_window div=%0b cycle %0d: got %b want %b",
                 is_div, k, o, vec_of(k <= n, k <= n));
      end
      tick();
      bus.E_md_start = 1'b0;
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] o;
    do_reset();
    bus.D_md_use = 1'b1;  bus.E_md_start = 1'b1;  bus.E_md_div = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      bus.E_md_start = 1'b0;
    end
    @(negedge clk);
    o = obs_vec();
    n_vec++;
    if (o !== vec_of(1'b1, 1'b1)) begin
      n_miss++;
      $display("FAIL mid_before_reset: got %b want %b", o, vec_of(1'b1, 1'b1));
    end
    #1;
    reset = 1'b1;  busy_end = -1;  m_cnt = 32'd0;
    #1;
    o = obs_vec();
    n_vec++;
    if (o !== vec_of(1'b0, 1'b0)) begin
      n_miss++;
      $display("FAIL mid_async_reset: got %b want %b", o, vec_of(1'b0, 1'b0));
    end
    n_vec++;
    if (bus.stall_cnt !== 32'd0) begin
      n_miss++;
      $display("FAIL mid_reset_cnt: got %0d want 0", bus.stall_cnt);
    end
    tick();
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      o = obs_vec();
      n_vec++;
      if (o !== vec_of(1'b0, 1'b0)) begin
        n_miss++;
        $display("FAIL mid_after_reset cycle %0d: got %b want %b", k, o, vec_of(1'b0, 1'b0));
      end
      tick();
    end
  endtask

  // One load-use stall, a gap, then a mult whose first cycle also has a register hazard.
  task automatic test_stall_cnt();
    logic [7:0]  o;
    logic [7:0]  e;
    logic [31:0] want7;
    do_reset();
    bus.E_wa = 5'd4;  bus.E_tnew = TNEW_LOAD_E;  bus.D_rs = 5'd4;  bus.D_rs_tuse = 2'd0;
    for (int k = 0; k < 10; k++) begin
      if (k == 1) set_idle();
      if (k == 2) begin
        bus.D_md_use = 1'b1;  bus.E_md_start = 1'b1;  bus.E_md_div = 1'b0;
        bus.E_wa = 5'd6;  bus.E_tnew = TNEW_ALU_E;  bus.D_rt = 5'd6;  bus.D_rt_tuse = 2'd0;
      end
      if (k == 3) begin
        bus.E_md_start = 1'b0;  bus.E_wa = 5'd0;
      end
      @(negedge clk);
      o = obs_vec();
      e = exp_vec();
      n_vec++;
      if (o !== e) begin
        n_miss++;
        $display("FAIL cnt_seq cycle %0d: got %b want %b", k, o, e);
      end
      tick();
    end
`ifdef STALL_CNT_EN
    want7 = 32'd7;
`else
    want7 = 32'd0;
`endif
    n_vec++;
    if (bus.stall_cnt !== want7) begin
      n_miss++;
      $display("FAIL stall_cnt_total: got %0d want %0d", bus.stall_cnt, want7);
    end
  endtask

  task automatic test_random();
    logic [7:0] o;
    logic [7:0] e;
    do_reset();
    for (int k = 0; k < 400; k++) begin
      bus.D_rs = 5'($urandom_range(0, 3));
      bus.D_rt = 5'($urandom_range(0, 3));
      bus.D_rs_tuse = 2'($urandom_range(0, 3));
      bus.D_rt_tuse = 2'($urandom_range(0, 3));
      bus.D_md_use = ($urandom_range(0, 1) == 1);
      bus.E_wa = 5'($urandom_range(0, 3));
      bus.M_wa = 5'($urandom_range(0, 3));
      bus.E_tnew = 2'($urandom_range(0, 2));
      bus.M_tnew = 2'($urandom_range(0, 1));
      bus.E_md_start = ($urandom_range(0, 9) == 0);
      bus.E_md_div = ($urandom_range(0, 1) == 1);
      @(negedge clk);
      o = obs_vec();
      e = exp_vec();
      n_vec++;
      if (o !== e) begin
        n_miss++;
        $display("FAIL random cycle %0d: got %b want %b", k, o, e);
      end
      n_vec++;
      if (bus.stall_cnt !== exp_cnt()) begin
        n_miss++;
        $display("FAIL random_cnt cycle %0d: got %0d want %0d", k, bus.stall_cnt, exp_cnt());
      end
      tick();
    end
  endtask

  initial begin
    reset = 1'b1;
    set_idle();
    test_reset();
    test_load_use();
    test_m_stage();
    test_md(1'b0);
    test_md(1'b1);
    test_reset_mid();
    test_stall_cnt();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
